// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 master controller.
package spi_pkg;

    localparam int unsigned SPI_DATA_W      = 8;
    localparam int unsigned SPI_DEFAULT_DIV = 1;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        NEXT,
        TRAIL
    } state_t;

endpackage

// File: rtl/sclk_tick_gen.sv
// Divider tick source: o_tick pulses for one cycle every (i_div+1) enabled cycles.
module sclk_tick_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit  = (r_cnt == i_div);
    // Tick is not masked by i_clear: the tick that ends a state also drives the clear.
    assign o_tick = i_en & w_hit;

    // Count enabled cycles; restart on clear, disable or terminal count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear || !i_en) begin
            r_cnt <= '0;
        end else if (w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: accepts words on a valid/ready stream, shifts them out
// MSB first on MOSI while capturing MISO, and frames them with CS_N.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = SPI_DEFAULT_DIV
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DIV_W-1:0]  i_div,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_last,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_busy,
    output logic              o_sclk,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic              o_cs_n
);

    localparam int unsigned       BCNT_W   = $clog2(DATA_W) + 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0]  DEF_DIV  = DIV_W'(DEFAULT_DIV);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_last;
    logic [DIV_W-1:0]    r_div;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic                r_sclk;
    logic                r_cs_n;
    logic                r_tx_ready;

    logic                w_accept;
    logic                w_tick;
    logic                w_tick_en;
    logic                w_tick_clr;
    logic                w_rise;
    logic                w_fall;
    logic                w_word_done;

    assign w_accept    = i_tx_valid & r_tx_ready;
    assign w_rise      = (r_state == SHIFT) & w_tick & ~r_sclk;
    assign w_fall      = (r_state == SHIFT) & w_tick & r_sclk;
    assign w_word_done = w_fall & (r_bit_cnt == LAST_BIT);
    assign w_tick_en   = (r_state == LEAD) | (r_state == SHIFT) | (r_state == TRAIL);
    assign w_tick_clr  = (w_next != r_state);

    assign o_tx_ready  = r_tx_ready;
    // Pulse is issued in the last SHIFT cycle so it never overlaps a NEXT accept.
    assign o_rx_valid  = w_word_done & i_rst_n;
    assign o_rx_data   = r_rx;
    assign o_busy      = (r_state != IDLE);
    assign o_sclk      = r_sclk;
    assign o_mosi      = r_tx[DATA_W-1];
    assign o_cs_n      = r_cs_n;

    sclk_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_tick_clr),
        .i_en    (w_tick_en),
        .i_div   (r_div),
        .o_tick  (w_tick)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic for the transfer sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_next = LEAD;
            LEAD:    if (w_tick)      w_next = SHIFT;
            SHIFT:   if (w_word_done) w_next = r_last ? TRAIL : NEXT;
            NEXT:    if (w_accept)    w_next = SHIFT;
            TRAIL:   if (w_tick)      w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // Registered handshake and chip-select, derived from the upcoming state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx_ready <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_tx_ready <= (w_next == IDLE) || (w_next == NEXT);
            r_cs_n     <= (w_next == IDLE);
        end
    end

    // Word latch, divider latch, SCLK toggling and the TX/RX shift registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_last    <= 1'b0;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tx      <= i_tx_data;
                r_last    <= i_tx_last;
                r_bit_cnt <= '0;
                if (r_state == IDLE) begin
                    r_div <= (i_div == '0) ? DEF_DIV : i_div;
                end
            end
            if (w_rise) begin
                r_sclk <= 1'b1;
                r_rx   <= {r_rx[DATA_W-2:0], i_miso};
            end
            if (w_fall) begin
                r_sclk    <= 1'b0;
                r_tx      <= {r_tx[DATA_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: table-driven single-word frames,
// hand-written multi-word, idle-NEXT, divider-change and reset-abort sequences,
// with an RX scoreboard queue.
module tb_spi_master_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_div;
    logic        i_tx_valid;
    logic        o_tx_ready;
    logic [7:0]  i_tx_data;
    logic        i_tx_last;
    logic        o_rx_valid;
    logic [7:0]  o_rx_data;
    logic        o_busy;
    logic        o_sclk;
    logic        o_mosi;
    logic        i_miso;
    logic        o_cs_n;

    // 0: loopback MOSI->MISO, 1: tied high, 2: tied low
    logic [1:0]  miso_mode;

    assign i_miso = (miso_mode == 2'd0) ? o_mosi : (miso_mode == 2'd1);

    spi_master_ctrl #(
        .DATA_W      (8),
        .DIV_W       (16),
        .DEFAULT_DIV (1)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_div      (i_div),
        .i_tx_valid (i_tx_valid),
        .o_tx_ready (o_tx_ready),
        .i_tx_data  (i_tx_data),
        .i_tx_last  (i_tx_last),
        .o_rx_valid (o_rx_valid),
        .o_rx_data  (o_rx_data),
        .o_busy     (o_busy),
        .o_sclk     (o_sclk),
        .o_mosi     (o_mosi),
        .i_miso     (i_miso),
        .o_cs_n     (o_cs_n)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        logic [1:0]  miso;
        logic [7:0]  exp_rx;
        int          period;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_rx     = 0;
    int         n_cs_fall = 0;
    int         n_cs_rise = 0;
    int         cs_fall_cyc = -1;
    logic       prev_sclk = 1'b0;
    logic       prev_cs   = 1'b1;
    int         rise_cyc[$];
    logic       rise_mosi[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and observe the DUT outputs there.
    task automatic tick();
        @(negedge i_clk);
        cyc++;
        if (o_sclk && !prev_sclk) begin
            rise_cyc.push_back(cyc);
            rise_mosi.push_back(o_mosi);
        end
        if (!o_cs_n && prev_cs) begin
            n_cs_fall++;
            cs_fall_cyc = cyc;
        end
        if (o_cs_n && !prev_cs) n_cs_rise++;
        if (o_rx_valid) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid (cycle %0d)", o_rx_data, cyc);
            end else begin
                chk("rx_data", int'(o_rx_data), int'(exp_q.pop_front()));
            end
        end
        prev_sclk = o_sclk;
        prev_cs   = o_cs_n;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic [15:0] dv,
                        input logic [7:0] exp_rx, output int acc_cyc);
        i_tx_data  = d;
        i_tx_last  = l;
        i_div      = dv;
        i_tx_valid = 1'b1;
        exp_q.push_back(exp_rx);
        acc_cyc = -1;
        for (int k = 0; k < 500; k++) begin
            if (o_tx_ready) begin
                acc_cyc = cyc;
                tick();
                break;
            end
            tick();
        end
        i_tx_valid = 1'b0;
        chk("accept_in_time", int'(acc_cyc >= 0), 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!o_busy) break;
            tick();
        end
        chk("idle_in_time", int'(o_busy), 0);
    endtask

    task automatic wait_rises(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (rise_cyc.size() >= target) break;
            tick();
        end
        chk("rises_in_time", int'(rise_cyc.size() >= target), 1);
    endtask

    task automatic periods(input int b, input int n, output int pmin, output int pmax);
        pmin = 1 << 30;
        pmax = 0;
        for (int i = b + 1; i < b + n && i < rise_cyc.size(); i++) begin
            if (rise_cyc[i] - rise_cyc[i-1] < pmin) pmin = rise_cyc[i] - rise_cyc[i-1];
            if (rise_cyc[i] - rise_cyc[i-1] > pmax) pmax = rise_cyc[i] - rise_cyc[i-1];
        end
    endtask

    function automatic logic [7:0] mosi_word(input int b);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (b + i < rise_mosi.size()) w = {w[6:0], rise_mosi[b+i]};
        end
        return w;
    endfunction

    task automatic run_single(input vec_t v);
        int rb, rxb, cfb, crb, acc, pmin, pmax;
        rb  = rise_cyc.size();
        rxb = n_rx;
        cfb = n_cs_fall;
        crb = n_cs_rise;
        miso_mode = v.miso;
        send(v.data, 1'b1, v.div, v.exp_rx, acc);
        chk("cs_low_latency", cs_fall_cyc - acc, 1);
        chk("busy_after_accept", int'(o_busy), 1);
        wait_idle(3000);
        chk("sclk_rises", rise_cyc.size() - rb, 8);
        chk("mosi_bits", int'(mosi_word(rb)), int'(v.data));
        periods(rb, 8, pmin, pmax);
        chk("sclk_period_min", pmin, v.period);
        chk("sclk_period_max", pmax, v.period);
        chk("rx_pulses", n_rx - rxb, 1);
        chk("cs_low_windows", n_cs_fall - cfb, 1);
        chk("cs_released", n_cs_rise - crb, 1);
        chk("cs_idle_high", int'(o_cs_n), 1);
        chk("sclk_idle_low", int'(o_sclk), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   acc, rb, rxb, cfb, crb, pmin, pmax, bad;

        vecs[0] = '{div: 16'd1, data: 8'hA5, miso: 2'd0, exp_rx: 8'hA5, period: 4};
        vecs[1] = '{div: 16'd0, data: 8'hA5, miso: 2'd0, exp_rx: 8'hA5, period: 4};
        vecs[2] = '{div: 16'd2, data: 8'h3C, miso: 2'd1, exp_rx: 8'hFF, period: 6};
        vecs[3] = '{div: 16'd1, data: 8'h5A, miso: 2'd2, exp_rx: 8'h00, period: 4};
        vecs[4] = '{div: 16'd3, data: 8'hC3, miso: 2'd0, exp_rx: 8'hC3, period: 8};

        i_rst_n    = 1'b0;
        i_div      = 16'd1;
        i_tx_valid = 1'b0;
        i_tx_data  = '0;
        i_tx_last  = 1'b0;
        miso_mode  = 2'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_tx_ready", int'(o_tx_ready), 0);
        chk("rst_rx_valid", int'(o_rx_valid), 0);
        chk("rst_rx_data",  int'(o_rx_data), 0);
        chk("rst_busy",     int'(o_busy), 0);
        chk("rst_sclk",     int'(o_sclk), 0);
        chk("rst_mosi",     int'(o_mosi), 0);
        chk("rst_cs_n",     int'(o_cs_n), 1);
        i_rst_n = 1'b1;
        tick();
        chk("ready_after_reset", int'(o_tx_ready), 1);

        // Single-word frames from the table
        for (int i = 0; i < 5; i++) begin
            run_single(vecs[i]);
            repeat (3) tick();
        end

        // Two-word frame, MISO high, no LEAD before the second word
        miso_mode = 2'd1;
        rb  = rise_cyc.size();
        rxb = n_rx;
        cfb = n_cs_fall;
        crb = n_cs_rise;
        send(8'h3C, 1'b0, 16'd1, 8'hFF, acc);
        send(8'hC3, 1'b1, 16'd1, 8'hFF, acc);
        wait_idle(3000);
        chk("two_word_rises", rise_cyc.size() - rb, 16);
        chk("two_word_rx_pulses", n_rx - rxb, 2);
        chk("two_word_cs_windows", n_cs_fall - cfb, 1);
        chk("two_word_cs_release", n_cs_rise - crb, 1);
        if (rise_cyc.size() >= rb + 9)
            chk("inter_word_gap", rise_cyc[rb+8] - rise_cyc[rb+7], 5);
        else
            chk("inter_word_gap", -1, 5);
        chk("word2_mosi", int'(mosi_word(rb + 8)), 8'hC3);
        repeat (3) tick();

        // NEXT holds the bus indefinitely between words
        miso_mode = 2'd0;
        rb  = rise_cyc.size();
        rxb = n_rx;
        crb = n_cs_rise;
        send(8'h96, 1'b0, 16'd1, 8'h96, acc);
        for (int k = 0; k < 500; k++) begin
            if (n_rx != rxb) break;
            tick();
        end
        chk("next_word_done", n_rx - rxb, 1);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (o_cs_n !== 1'b0 || o_sclk !== 1'b0 || o_tx_ready !== 1'b1 || o_busy !== 1'b1) bad++;
        end
        chk("next_hold_bad_cycles", bad, 0);
        send(8'h01, 1'b1, 16'd1, 8'h01, acc);
        wait_idle(3000);
        chk("next_total_rises", rise_cyc.size() - rb, 16);
        chk("next_cs_release", n_cs_rise - crb, 1);
        chk("next_word2_mosi", int'(mosi_word(rb + 8)), 8'h01);
        repeat (3) tick();

        // Divider change mid-frame is ignored until the next frame
        rb = rise_cyc.size();
        send(8'hA5, 1'b1, 16'd1, 8'hA5, acc);
        wait_rises(rb + 3, 500);
        i_div = 16'd7;
        wait_idle(3000);
        periods(rb, 8, pmin, pmax);
        chk("divchg_rises", rise_cyc.size() - rb, 8);
        chk("divchg_period_min", pmin, 4);
        chk("divchg_period_max", pmax, 4);
        repeat (3) tick();
        run_single('{div: 16'd7, data: 8'h69, miso: 2'd0, exp_rx: 8'h69, period: 16});
        repeat (3) tick();

        // Reset in the middle of a frame
        rb = rise_cyc.size();
        send(8'hA5, 1'b1, 16'd1, 8'hA5, acc);
        wait_rises(rb + 3, 500);
        i_rst_n = 1'b0;
        rxb = n_rx;
        tick();
        chk("abort_cs_n", int'(o_cs_n), 1);
        chk("abort_sclk", int'(o_sclk), 0);
        chk("abort_ready", int'(o_tx_ready), 0);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_rx_valid", int'(o_rx_valid), 0);
        exp_q.delete();
        repeat (2) tick();
        i_rst_n = 1'b1;
        repeat (3) tick();
        chk("abort_no_rx", n_rx - rxb, 0);
        chk("abort_ready_back", int'(o_tx_ready), 1);
        run_single('{div: 16'd1, data: 8'h5A, miso: 2'd0, exp_rx: 8'h5A, period: 4});
        repeat (3) tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
